// File: rtl/shift_left_seq_if.sv
// Request/result bundle for the sequential left shifter.
// The master issues start/a/sh_amt and the slave returns dataout/busy/done.
interface shift_left_seq_if #(
  parameter int WIDTH = 16,
  parameter int SW    = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [SW-1:0]    sh_amt;
  logic [WIDTH-1:0] dataout;
  logic             busy;
  logic             done;

  modport master (
    output start, a, sh_amt,
    input  dataout, busy, done
  );

  modport slave (
    input  start, a, sh_amt,
    output dataout, busy, done
  );
endinterface

// File: rtl/shift_left_seq.sv
// Multi-cycle left shifter: shifts the captured operand by up to two bit
// positions per clock until the requested distance has been consumed.
module shift_left_seq #(
  parameter int WIDTH = 16,
  parameter int SW    = 4
) (
  input  logic              clk,
  input  logic              reset,
  shift_left_seq_if.slave   bus
);

  if (2**SW != WIDTH) begin : g_bad_params
    $error("shift_left_seq: 2**SW must equal WIDTH");
  end

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] data_q;
  logic [SW-1:0]    cnt_q;

  // Remaining distance after one step; saturates at zero so it cannot wrap.
  function automatic logic [SW-1:0] next_cnt(input logic [SW-1:0] cnt);
    if (cnt >= SW'(2)) next_cnt = cnt - SW'(2);
    else               next_cnt = '0;
  endfunction

  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [SW-1:0]    cnt);
    if (cnt >= SW'(2)) shift_step = {d[WIDTH-3:0], 2'b00};
    else               shift_step = {d[WIDTH-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            data_q <= bus.a;
            cnt_q  <= bus.sh_amt;
            state  <= (bus.sh_amt != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          data_q <= shift_step(data_q, cnt_q);
          cnt_q  <= next_cnt(cnt_q);
          if (next_cnt(cnt_q) == '0) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dataout = data_q;
  assign bus.busy    = (state == SHIFT);
  assign bus.done    = (state == DONE);

endmodule

// File: tb/tb_shift_left_seq.sv
// Scoreboard bench for shift_left_seq: driver pushes expected results,
// a forked monitor pops and checks them whenever done is presented.
module tb_shift_left_seq;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    logic [15:0] res;
    int          done_cyc;
    int          busy_len;
  } exp_t;

  exp_t        q[$];
  logic [15:0] last_res;
  int          busy_run;

  shift_left_seq_if #(.WIDTH(16), .SW(4)) bus ();

  shift_left_seq #(.WIDTH(16), .SW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0b done=%0b after 40 cycles, required idle", bus.busy, bus.done);
    end
  endtask

  // Issues one request and returns just after the accepting edge.
  task automatic run_op(input logic [15:0] av, input logic [3:0] sv);
    exp_t e;
    int   c;
    @(negedge clk);
    wait_idle();
    c          = cyc;
    bus.start  = 1'b1;
    bus.a      = av;
    bus.sh_amt = sv;
    @(posedge clk);
    e.res      = 16'((32'(av) << sv) % 32'h1_0000);
    e.busy_len = (int'(sv) + 1) / 2;
    e.done_cyc = c + 1 + e.busy_len;
    q.push_back(e);
    #1 bus.start = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        last_res = '0;
        busy_run = 0;
      end else begin
        if (bus.busy) busy_run++;
        if (bus.done) begin
          check("done_not_busy", {31'd0, bus.busy}, 32'd0);
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 dataout=%0h, required no done", bus.dataout);
          end else begin
            e = q.pop_front();
            check("result", {16'd0, bus.dataout}, {16'd0, e.res});
            check("latency", cyc, e.done_cyc);
            check("busy_cycles", busy_run, e.busy_len);
            last_res = e.res;
          end
          busy_run = 0;
        end else if (!bus.busy) begin
          check("hold", {16'd0, bus.dataout}, {16'd0, last_res});
        end
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    last_res   = '0;
    busy_run   = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.a      = '0;
    bus.sh_amt = '0;

    #1;
    check("rst_dataout", {16'd0, bus.dataout}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);

    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Basic shift with an odd distance: one double step then one single step.
    run_op(16'h00F1, 4'd3);
    @(negedge clk);
    check("f1_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    check("f1_step1", {16'd0, bus.dataout}, 32'h03C4);
    @(negedge clk);
    check("f1_done", {31'd0, bus.done}, 32'd1);
    check("f1_final", {16'd0, bus.dataout}, 32'h0788);

    run_op(16'hABCD, 4'd0);
    @(negedge clk);
    check("zero_done", {31'd0, bus.done}, 32'd1);
    check("zero_busy", {31'd0, bus.busy}, 32'd0);
    check("zero_data", {16'd0, bus.dataout}, 32'hABCD);

    run_op(16'hFFFF, 4'd15);
    @(negedge clk);
    wait_idle();
    repeat (3) @(negedge clk);
    check("max_hold", {16'd0, bus.dataout}, 32'h8000);

    // Starts arriving in SHIFT and in DONE must not disturb the operation.
    run_op(16'h0001, 4'd8);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'hFFFF; bus.sh_amt = 4'd1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.done && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("ign_done_seen", {31'd0, bus.done}, 32'd1);
    end
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("ign_idle_busy", {31'd0, bus.busy}, 32'd0);
    check("ign_idle_done", {31'd0, bus.done}, 32'd0);
    check("ign_result", {16'd0, bus.dataout}, 32'h0100);

    // Asynchronous abort mid-operation.
    run_op(16'h1234, 4'd10);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_dataout", {16'd0, bus.dataout}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    run_op(16'h0003, 4'd2);
    @(negedge clk);
    wait_idle();
    check("post_reset", {16'd0, bus.dataout}, 32'h000C);

    // Random sweep across every shift distance.
    for (int s = 0; s < 16; s++) begin
      for (int k = 0; k < 3; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        run_op(16'($urandom), 4'(s));
      end
    end

    @(negedge clk);
    wait_idle();
    repeat (2) @(negedge clk);
    check("queue_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_left_seq.md
SHIFT_LEFT_SEQ -- requirements
Module: shift_left_seq

Interface
REQ-001 Parameter: WIDTH, 16, data path width in bits.
REQ-002 Parameter: SW, 4, shift-amount width; the block SHALL require 2**SW == WIDTH.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  request strobe; sampled on the rising edge of clk.
REQ-006 Port: a  input  WIDTH  operand; captured when start is accepted.
REQ-007 Port: sh_amt  input  SW  left-shift distance, 0..WIDTH-1; captured with a.
REQ-008 Port: dataout  output  WIDTH  registered result, a << sh_amt with zero fill from bit 0.
REQ-009 Port: busy  output  1  high while a shift operation is in progress.
REQ-010 Port: done  output  1  one-cycle pulse; dataout is valid and final while done is high.

Function
REQ-011 The state machine SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE, start=1 SHALL load a into the data register and sh_amt into the remaining-count register.
REQ-013 In IDLE with start=1, the next state SHALL be SHIFT when sh_amt != 0, and DONE when sh_amt == 0.
REQ-014 In SHIFT, on each edge with count >= 2, the block SHALL shift data left by 2, insert 0 at bits [1:0], and decrement count by 2.
REQ-015 In SHIFT, on an edge with count == 1, the block SHALL shift data left by 1, insert 0 at bit 0, and set count to 0.
REQ-016 SHIFT SHALL move to DONE on the edge where the updated count becomes 0; otherwise it SHALL remain in SHIFT.
REQ-017 DONE SHALL last exactly one cycle and SHALL then move to IDLE unconditionally.
REQ-018 Latency: done SHALL go high exactly ceil(sh_amt/2)+1 edges after the accepting edge (sh_amt=0 gives 1 edge).
REQ-019 busy SHALL be 1 exactly while the state is SHIFT; done SHALL be 1 exactly while the state is DONE.
REQ-020 start SHALL be ignored in SHIFT and DONE; the in-flight operation and its operands SHALL be unaffected.
REQ-021 dataout SHALL reflect the data register, hold the final result after DONE, and change only when a new start is accepted.
REQ-022 Bits shifted out of the MSB SHALL be discarded, with no overflow indication.
REQ-023 The datapath SHALL contain no arithmetic other than the count decrement; count SHALL never underflow below 0.

Reset
REQ-024 Asserting reset SHALL immediately force state=IDLE, data register=0, count=0, dataout=0, busy=0, done=0, regardless of clk.
REQ-025 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow it.
REQ-026 The first start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-027 a=16'h00F1, sh_amt=3, single start -> next edge busy=1; dataout 16'h03C4, then 16'h0788; done=1 with dataout=16'h0788 three edges after the accepting edge; busy=0.
REQ-028 a=16'hABCD, sh_amt=0 -> busy never high; done=1 on the edge after acceptance with dataout=16'hABCD.
REQ-029 a=16'hFFFF, sh_amt=15 -> busy high for 8 cycles (7 shifts by 2, 1 shift by 1); done with dataout=16'h8000; then IDLE, dataout held at 16'h8000.
REQ-030 Accept a=16'h0001, sh_amt=8; pulse start with a=16'hFFFF, sh_amt=1 during SHIFT and during DONE -> both ignored; result 16'h0100; busy high 4 cycles.
REQ-031 Assert reset asynchronously while busy (a=16'h1234, sh_amt=10) -> dataout=0, busy=0, done=0 immediately, no done pulse; after release, a=16'h0003, sh_amt=2 gives 16'h000C.
REQ-032 Random sweep of a and all sh_amt values 0..15 -> every result equals (a << sh_amt) mod 2**16, with latency per REQ-018.
